router_ingress_fifo: RTL and testbench

Clocked ingress stage that sits directly upstream of the combinational 4-port router and drives its din_en/addr/din inputs. Accepts routed words on a valid/ready interface and buffers them in a DEPTH-entry FIFO. Issues at most one word per cycle to the router as a one-cycle din_en pulse with registered addr/din. The router has no backpressure, so any throttling of traffic happens here, via out_stall.

---
 rtl/router_pkg.sv | 13 +
 rtl/router_ingress_fifo_sync_fifo.sv | 68 ++++++
 rtl/router_ingress_fifo.sv | 74 +++++++
 tb/tb_router_ingress_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared widths and the request word carried from the ingress FIFO to the 4-port router.
package router_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 2;
  localparam int NUM_PORTS = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } route_req_t;

endpackage

// File: rtl/router_ingress_fifo_sync_fifo.sv
// Generic route_req_t FIFO: storage, wrapping pointers and an occupancy count.
// Full and empty come from the count, so pointers never need an extra wrap bit.
module sync_fifo
  import router_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  route_req_t       wdata_i,
  input  logic             pop_i,
  output route_req_t       rdata_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  route_req_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; only entries below the level are ever read.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/router_ingress_fifo.sv
// Ingress buffer ahead of the combinational router: valid/ready in, one registered
// din_en strobe with addr/din per issued word out, throttled by out_stall and cleared by flush.
module router_ingress_fifo
  import router_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              out_stall,
  output logic              din_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  output logic [LVL_W-1:0]  level
);

  route_req_t        wr_req, head;
  logic              full, empty, push, pop;
  logic              din_en_q, din_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;

  // Ready ignores in_valid and sees no pop of the same edge: a full FIFO refuses even while draining.
  assign in_ready = rst_n && !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = !flush && !out_stall && !empty;
  assign wr_req   = '{addr: in_addr, data: in_data};

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .push_i  (push),
    .wdata_i (wr_req),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    din_en_d = pop;
    addr_d   = addr_q;
    din_d    = din_q;
    if (pop) begin
      addr_d = head.addr;
      din_d  = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_en_q <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      din_en_q <= din_en_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign din_en = din_en_q;
  assign addr   = addr_q;
  assign din    = din_q;

endmodule

// File: tb/tb_router_ingress_fifo.sv
// Scoreboard bench for router_ingress_fifo: a queue model predicts stored and issued words,
// a negedge monitor compares every cycle, directed tests add latency/flush/reset checks.
module tb_router_ingress_fifo;
  import router_pkg::*;

  localparam int DEPTH = 8;
  localparam int LVL_W = 4;
  localparam int NRAND = DEPTH * 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              out_stall = 1'b0;
  logic              din_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [LVL_W-1:0]  level;

  router_ingress_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .flush(flush), .out_stall(out_stall),
    .din_en(din_en), .addr(addr), .din(din), .level(level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_issued = 0;
  int port_cnt [NUM_PORTS];

  route_req_t        model_q[$];
  route_req_t        exp_q[$];
  route_req_t        mon_r;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_din = '0;
  bit                m_pop, m_push, exp_en;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue, an issued word moves to exp_q to be seen next cycle.
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        model_q.delete();
      end else begin
        m_pop  = (model_q.size() != 0) && !out_stall;
        m_push = in_valid && (model_q.size() < DEPTH);
        if (m_pop)  exp_q.push_back(model_q.pop_front());
        if (m_push) model_q.push_back('{addr: in_addr, data: in_data});
      end
    end
  end

  always @(negedge rst_n) begin
    model_q.delete();
    exp_q.delete();
    last_addr = '0;
    last_din  = '0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_en = (exp_q.size() != 0);
      check("din_en", 64'(din_en), 64'(exp_en));
      if (exp_en) begin
        mon_r     = exp_q.pop_front();
        last_addr = mon_r.addr;
        last_din  = mon_r.data;
      end
      if (din_en) begin
        n_issued++;
        port_cnt[addr]++;
      end
      check("addr", 64'(addr), 64'(last_addr));
      check("din", 64'(din), 64'(last_din));
      check("level", 64'(level), 64'(model_q.size()));
      check("in_ready", 64'(in_ready), 64'((model_q.size() < DEPTH) && !flush));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_acc(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
  endtask

  int exp_port [NUM_PORTS];
  bit acc;
  int idx;

  initial begin
    // Reset state
    #2;
    check("rst_din_en", 64'(din_en), 64'(0));
    check("rst_addr", 64'(addr), 64'(0));
    check("rst_din", 64'(din), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    #10 rst_n = 1'b1;
    tick();

    // 1: two-cycle latency
    drive(1'b1, 2'b01, 32'hA1B2_C3D4);
    tick();
    drive(1'b0, '0, '0);
    check("lat_edgeN", 64'(din_en), 64'(0));
    tick();
    check("lat_edgeN1_en", 64'(din_en), 64'(1));
    check("lat_edgeN1_addr", 64'(addr), 64'(2'b01));
    check("lat_edgeN1_din", 64'(din), 64'(32'hA1B2_C3D4));
    tick();

    // 2: fill under stall, hold a ninth word, then drain
    out_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, ADDR_W'(i % 4), 32'h8765_4320 + 32'(i));
      tick();
    end
    drive(1'b1, 2'b11, 32'h9999_0009);
    check("full_level", 64'(level), 64'(DEPTH));
    check("full_ready", 64'(in_ready), 64'(0));
    tick();
    tick();
    out_stall = 1'b0;
    tick_acc(acc);
    check("full_no_push_on_pop", 64'(acc), 64'(0));
    tick_acc(acc);
    check("ninth_accept", 64'(acc), 64'(1));
    drive(1'b0, '0, '0);
    repeat (12) tick();

    // 3: steady push/pop at level 3
    out_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(i), 32'h3000_0000 + 32'(i));
      tick();
    end
    out_stall = 1'b0;
    for (int i = 3; i < 23; i++) begin
      drive(1'b1, ADDR_W'(i), 32'h3000_0000 + 32'(i));
      tick();
      check("steady_level", 64'(level), 64'(3));
    end
    drive(1'b0, '0, '0);
    repeat (5) tick();

    // 4: flush drops buffered words and the word presented with it
    out_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ADDR_W'(i), 32'h4000_0000 + 32'(i));
      tick();
    end
    drive(1'b1, 2'b10, 32'hDEAD_BEEF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("flush_level", 64'(level), 64'(0));
    check("flush_din_en", 64'(din_en), 64'(0));
    check("flush_hold_addr", 64'(addr), 64'(last_addr));
    check("flush_hold_din", 64'(din), 64'(last_din));
    out_stall = 1'b0;
    repeat (4) tick();

    // 5: async reset mid-burst
    out_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ADDR_W'(i + 1), 32'h5000_0000 + 32'(i));
      tick();
    end
    drive(1'b0, '0, '0);
    out_stall = 1'b0;
    tick();
    check("mid_burst_level", 64'(level), 64'(4));
    #2 rst_n = 1'b0;
    #1;
    check("arst_din_en", 64'(din_en), 64'(0));
    check("arst_addr", 64'(addr), 64'(0));
    check("arst_din", 64'(din), 64'(0));
    check("arst_level", 64'(level), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) tick();

    // 6: random traffic with random stall across pointer wrap
    n_issued = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_cnt[p] = 0;
      exp_port[p] = 0;
    end
    idx = 0;
    for (int cyc = 0; cyc < 2000 && (idx < NRAND || model_q.size() != 0 || exp_q.size() != 0); cyc++) begin
      if (!in_valid && idx < NRAND && $urandom_range(9) < 7) begin
        drive(1'b1, ADDR_W'($urandom), $urandom);
      end
      out_stall = ($urandom_range(9) < 4);
      tick_acc(acc);
      if (acc) begin
        exp_port[in_addr]++;
        in_valid = 1'b0;
        idx++;
      end
    end
    out_stall = 1'b0;
    tick();
    check("rand_all_pushed", 64'(idx), 64'(NRAND));
    check("rand_drained", 64'(model_q.size()), 64'(0));
    check("rand_issued", 64'(n_issued), 64'(NRAND));
    for (int p = 0; p < NUM_PORTS; p++) begin
      check("rand_port_count", 64'(port_cnt[p]), 64'(exp_port[p]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
